// File: rtl/mdu.sv
// Iterative RV64M multiply/divide unit: 64-step shift-add multiply and restoring divide.
// Fixed 65-cycle latency from accept to the single-cycle result pulse.
module mdu (
   input  logic        clk,
   input  logic        reset,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [3:0]  op,
   input  logic [63:0] a,
   input  logic [63:0] b,
   input  logic        flush,
   output logic        out_valid,
   output logic [63:0] c
);

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   state_t      state;
   logic [5:0]  count;
   logic [3:0]  op_q;
   logic [63:0] acc, x, y, dividend_q;
   logic        neg_q, rneg_q, zero_q, ovf_q;

   logic        w_sext, div_signed, is_mul, ovf;
   logic [63:0] ea, eb, ma, mb;

   logic [63:0] mul_sum, rem_n, quo_n, q, r, raw, result;
   logic [64:0] trial, diff;

   // Operand conditioning for the op being offered; only consumed on accept.
   always_comb begin
      w_sext     = (op[2:0] == 3'd0) || (op[2:0] == 3'd1) || (op[2:0] == 3'd3);
      div_signed = (op[2:0] == 3'd1) || (op[2:0] == 3'd3);
      is_mul     = (op[2:0] == 3'd0);
      ea = a;
      eb = b;
      if (op[3]) begin
         ea = w_sext ? {{32{a[31]}}, a[31:0]} : {32'd0, a[31:0]};
         eb = w_sext ? {{32{b[31]}}, b[31:0]} : {32'd0, b[31:0]};
      end
      ma  = (div_signed && ea[63]) ? -ea : ea;
      mb  = (div_signed && eb[63]) ? -eb : eb;
      ovf = div_signed && (eb == '1) &&
            (ea == (op[3] ? 64'hFFFF_FFFF_8000_0000 : 64'h8000_0000_0000_0000));
   end

   // One iteration of either algorithm, plus the result as it would be after this step.
   always_comb begin
      mul_sum = acc + (x[0] ? y : 64'd0);
      trial   = {acc, x[63]};
      diff    = trial - {1'b0, y};
      if (diff[64]) begin
         rem_n = trial[63:0];
         quo_n = {x[62:0], 1'b0};
      end else begin
         rem_n = diff[63:0];
         quo_n = {x[62:0], 1'b1};
      end
      q = neg_q  ? -quo_n : quo_n;
      r = rneg_q ? -rem_n : rem_n;
      if (zero_q) begin
         q = '1;
         r = dividend_q;
      end else if (ovf_q) begin
         q = dividend_q;
         r = '0;
      end
      case (op_q[2:0])
         3'd0:       raw = mul_sum;
         3'd1, 3'd2: raw = q;
         3'd3, 3'd4: raw = r;
         default:    raw = '0;
      endcase
      result = op_q[3] ? {{32{raw[31]}}, raw[31:0]} : raw;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         count      <= '0;
         c          <= '0;
         op_q       <= '0;
         acc        <= '0;
         x          <= '0;
         y          <= '0;
         dividend_q <= '0;
         neg_q      <= 1'b0;
         rneg_q     <= 1'b0;
         zero_q     <= 1'b0;
         ovf_q      <= 1'b0;
      end else if (flush) begin
         state <= IDLE;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  state      <= BUSY;
                  count      <= '0;
                  op_q       <= op;
                  acc        <= '0;
                  x          <= is_mul ? eb : ma;
                  y          <= is_mul ? ea : mb;
                  dividend_q <= ea;
                  neg_q      <= div_signed && (ea[63] ^ eb[63]);
                  rneg_q     <= div_signed && ea[63];
                  zero_q     <= (eb == '0);
                  ovf_q      <= ovf;
               end
            end
            BUSY: begin
               // Multiply consumes x from the LSB; divide shifts quotient bits into x.
               acc   <= (op_q[2:0] == 3'd0) ? mul_sum : rem_n;
               x     <= (op_q[2:0] == 3'd0) ? (x >> 1) : quo_n;
               y     <= (op_q[2:0] == 3'd0) ? (y << 1) : y;
               count <= count + 6'd1;
               if (count == 6'd63) begin
                  c     <= result;
                  state <= DONE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign in_ready  = (state == IDLE);
   assign out_valid = (state == DONE) & ~flush;

endmodule

// File: tb/tb_mdu.sv
// Directed-vector bench for mdu: arithmetic results, special cases, latency, flush and reset.
module tb_mdu;

   logic        clk = 1'b0;
   logic        reset, in_valid, flush;
   logic        in_ready, out_valid;
   logic [3:0]  op;
   logic [63:0] a, b, c;

   int vectors = 0;
   int miscompares = 0;

   mdu dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
      .op(op), .a(a), .b(b), .flush(flush), .out_valid(out_valid), .c(c)
   );

   always #5 clk = ~clk;

   // Offers one op at a negedge and returns at the negedge of cycle T+1.
   task automatic accept(input logic [3:0] o, input logic [63:0] x, input logic [63:0] y);
      @(negedge clk);
      in_valid = 1'b1; op = o; a = x; b = y;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   // Runs one op through to T+66, recording result, latency, pulse count and in_ready errors.
   task automatic run_op(input logic [3:0] o, input logic [63:0] x, input logic [63:0] y,
                         input bit scramble, output logic [63:0] res, output int lat,
                         output int pulses, output bit rbad);
      res = 'x; lat = 0; pulses = 0; rbad = 1'b0;
      @(negedge clk);
      if (!in_ready) rbad = 1'b1;
      accept(o, x, y);
      if (scramble) begin
         op = 4'd0; a = 64'hDEAD_BEEF_0BAD_F00D; b = 64'h0123_4567_89AB_CDEF;
      end
      for (int k = 1; k <= 66; k++) begin
         if (k > 1) @(negedge clk);
         if (out_valid) begin
            pulses++;
            if (lat == 0) lat = k;
            res = c;
         end
         if (in_ready !== (k == 66)) rbad = 1'b1;
      end
   endtask

   task automatic test_reset;
      reset = 1'b1; in_valid = 1'b0; flush = 1'b0; op = '0; a = '0; b = '0;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      vectors++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0 || c !== 64'd0) begin
         miscompares++;
         $display("[TB] FAIL reset: in_ready=%b out_valid=%b c=%h, want 1 0 0", in_ready, out_valid, c);
      end
   endtask

   task automatic test_mul;
      logic [3:0]  ops [3] = '{4'd0, 4'd0, 4'd0};
      logic [63:0] as  [3] = '{64'd7, 64'h0000_0001_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF};
      logic [63:0] bs  [3] = '{64'hFFFF_FFFF_FFFF_FFFD, 64'h0000_0001_0000_0003, 64'hFFFF_FFFF_FFFF_FFFF};
      logic [63:0] ex  [3] = '{64'hFFFF_FFFF_FFFF_FFEB, 64'h0000_0003_0000_0000, 64'd1};
      logic [63:0] res; int lat, pulses; bit rbad;
      for (int i = 0; i < 3; i++) begin
         run_op(ops[i], as[i], bs[i], 1'b0, res, lat, pulses, rbad);
         vectors++;
         if (res !== ex[i] || lat != 65 || pulses != 1 || rbad) begin
            miscompares++;
            $display("[TB] FAIL mul[%0d]: c=%h lat=%0d pulses=%0d rdy_err=%0b, want c=%h lat=65 pulses=1 rdy_err=0",
                     i, res, lat, pulses, rbad, ex[i]);
         end
      end
   endtask

   task automatic test_divide;
      logic [3:0]  ops [4] = '{4'd1, 4'd3, 4'd4, 4'd2};
      logic [63:0] as  [4] = '{64'hFFFF_FFFF_FFFF_FFF9, 64'hFFFF_FFFF_FFFF_FFF9, 64'd7, 64'd100};
      logic [63:0] bs  [4] = '{64'd2, 64'd2, 64'd2, 64'd7};
      logic [63:0] ex  [4] = '{64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd14};
      logic [63:0] res; int lat, pulses; bit rbad;
      for (int i = 0; i < 4; i++) begin
         run_op(ops[i], as[i], bs[i], 1'b0, res, lat, pulses, rbad);
         vectors++;
         if (res !== ex[i] || lat != 65 || pulses != 1 || rbad) begin
            miscompares++;
            $display("[TB] FAIL div[%0d]: c=%h lat=%0d pulses=%0d rdy_err=%0b, want c=%h lat=65 pulses=1 rdy_err=0",
                     i, res, lat, pulses, rbad, ex[i]);
         end
      end
   endtask

   task automatic test_special;
      logic [3:0]  ops [6] = '{4'd2, 4'd3, 4'd1, 4'd3, 4'd4, 4'd5};
      logic [63:0] as  [6] = '{64'd5, 64'd5, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000,
                               64'hFFFF_FFFF_FFFF_FFFF, 64'd9};
      logic [63:0] bs  [6] = '{64'd0, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 64'd3};
      logic [63:0] ex  [6] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'd5, 64'h8000_0000_0000_0000, 64'd0,
                               64'hFFFF_FFFF_FFFF_FFFF, 64'd0};
      logic [63:0] res; int lat, pulses; bit rbad;
      for (int i = 0; i < 6; i++) begin
         run_op(ops[i], as[i], bs[i], 1'b0, res, lat, pulses, rbad);
         vectors++;
         if (res !== ex[i] || lat != 65 || pulses != 1 || rbad) begin
            miscompares++;
            $display("[TB] FAIL special[%0d]: c=%h lat=%0d pulses=%0d rdy_err=%0b, want c=%h lat=65 pulses=1 rdy_err=0",
                     i, res, lat, pulses, rbad, ex[i]);
         end
      end
   endtask

   task automatic test_word;
      logic [3:0]  ops [5] = '{4'd8, 4'd10, 4'd9, 4'd9, 4'd12};
      logic [63:0] as  [5] = '{64'h0000_0001_0000_0002, 64'h0000_0000_FFFF_FFFF, 64'h0000_0000_8000_0000,
                               64'h1234_5678_FFFF_FFF9, 64'h0000_0000_8000_0005};
      logic [63:0] bs  [5] = '{64'h0000_0000_4000_0000, 64'd1, 64'h0000_0000_FFFF_FFFF,
                               64'hABCD_0000_0000_0002, 64'hFFFF_FFFF_0000_0000};
      logic [63:0] ex  [5] = '{64'hFFFF_FFFF_8000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_8000_0000,
                               64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_8000_0005};
      logic [63:0] res; int lat, pulses; bit rbad;
      for (int i = 0; i < 5; i++) begin
         run_op(ops[i], as[i], bs[i], 1'b0, res, lat, pulses, rbad);
         vectors++;
         if (res !== ex[i] || lat != 65 || pulses != 1 || rbad) begin
            miscompares++;
            $display("[TB] FAIL word[%0d]: c=%h lat=%0d pulses=%0d rdy_err=%0b, want c=%h lat=65 pulses=1 rdy_err=0",
                     i, res, lat, pulses, rbad, ex[i]);
         end
      end
   endtask

   task automatic test_latched;
      logic [63:0] res; int lat, pulses; bit rbad;
      run_op(4'd2, 64'd100, 64'd7, 1'b1, res, lat, pulses, rbad);
      vectors++;
      if (res !== 64'd14 || lat != 65 || pulses != 1) begin
         miscompares++;
         $display("[TB] FAIL latched: c=%h lat=%0d pulses=%0d, want c=%h lat=65 pulses=1", res, lat, pulses, 64'd14);
      end
   endtask

   task automatic test_flush;
      logic [63:0] res; int lat, pulses; bit rbad;
      bit seen;
      run_op(4'd1, 64'd9, 64'd3, 1'b0, res, lat, pulses, rbad);
      vectors++;
      if (res !== 64'd3) begin
         miscompares++;
         $display("[TB] FAIL flush_setup: c=%h, want %h", res, 64'd3);
      end
      // Flush mid-BUSY at T+30.
      seen = 1'b0;
      accept(4'd1, 64'd100, 64'd7);
      for (int k = 1; k <= 30; k++) begin
         if (k > 1) @(negedge clk);
         if (out_valid) seen = 1'b1;
      end
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      vectors++;
      if (in_ready !== 1'b1) begin
         miscompares++;
         $display("[TB] FAIL flush_ready: in_ready=%b at T+31, want 1", in_ready);
      end
      repeat (70) begin
         @(negedge clk);
         if (out_valid) seen = 1'b1;
      end
      vectors++;
      if (seen || c !== 64'd3) begin
         miscompares++;
         $display("[TB] FAIL flush_busy: pulse_seen=%0b c=%h, want 0 and %h", seen, c, 64'd3);
      end
      // Flush in IDLE must block a simultaneous request.
      @(negedge clk);
      in_valid = 1'b1; flush = 1'b1; op = 4'd0; a = 64'd1; b = 64'd1;
      @(negedge clk);
      in_valid = 1'b0; flush = 1'b0;
      vectors++;
      if (in_ready !== 1'b1) begin
         miscompares++;
         $display("[TB] FAIL flush_idle: in_ready=%b, want 1", in_ready);
      end
      // Flush during the DONE cycle.
      accept(4'd2, 64'd100, 64'd7);
      repeat (64) @(negedge clk);
      flush = 1'b1;
      #1;
      vectors++;
      if (out_valid !== 1'b0) begin
         miscompares++;
         $display("[TB] FAIL flush_done: out_valid=%b, want 0", out_valid);
      end
      @(negedge clk);
      flush = 1'b0;
      vectors++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
         miscompares++;
         $display("[TB] FAIL flush_done_after: in_ready=%b out_valid=%b, want 1 0", in_ready, out_valid);
      end
   endtask

   task automatic test_reset_busy;
      bit seen = 1'b0;
      accept(4'd0, 64'd7, 64'd3);
      repeat (19) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      vectors++;
      if (c !== 64'd0 || in_ready !== 1'b1 || out_valid !== 1'b0) begin
         miscompares++;
         $display("[TB] FAIL reset_busy: c=%h in_ready=%b out_valid=%b, want 0 1 0", c, in_ready, out_valid);
      end
      repeat (70) begin
         @(negedge clk);
         if (out_valid) seen = 1'b1;
      end
      vectors++;
      if (seen) begin
         miscompares++;
         $display("[TB] FAIL reset_busy_pulse: pulse_seen=%0b, want 0", seen);
      end
   endtask

   task automatic test_back_to_back;
      int acc_idx [$];
      int good = 0, pulses = 0;
      @(negedge clk);
      in_valid = 1'b1; op = 4'd0; a = 64'd3; b = 64'd5;
      for (int n = 0; n < 200; n++) begin
         if (n > 0) @(negedge clk);
         if (in_ready) acc_idx.push_back(n);
         if (out_valid) begin
            pulses++;
            if (c === 64'd15) good++;
         end
      end
      in_valid = 1'b0;
      vectors++;
      if (acc_idx.size() != 4) begin
         miscompares++;
         $display("[TB] FAIL b2b_count: accepts=%0d, want 4", acc_idx.size());
      end else begin
         for (int i = 1; i < 4; i++) begin
            vectors++;
            if (acc_idx[i] - acc_idx[i-1] != 66) begin
               miscompares++;
               $display("[TB] FAIL b2b_gap[%0d]: gap=%0d, want 66", i, acc_idx[i] - acc_idx[i-1]);
            end
         end
      end
      vectors++;
      if (pulses != 3 || good != 3) begin
         miscompares++;
         $display("[TB] FAIL b2b_results: pulses=%0d correct=%0d, want 3 3", pulses, good);
      end
      repeat (70) @(negedge clk);
   endtask

   initial begin
      test_reset();
      test_mul();
      test_divide();
      test_special();
      test_word();
      test_latched();
      test_flush();
      test_reset_busy();
      test_back_to_back();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
